// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Pops bytes from a synchronous FIFO read port and serialises each byte as an
// asynchronous UART frame: start bit, LSB-first data, optional parity bit,
// then one or two stop bits. The FIFO is never read while it reports empty.
//
// Ports:
//   clk          - rising-edge clock
//   rstn         - asynchronous active-low reset
//   enable       - permits starting new frames (a frame in flight always completes)
//   fifo_empty   - FIFO empty flag
//   fifo_rd_data - FIFO read data (registered in the FIFO, valid the cycle after
//                  the read enable is sampled)
//   fifo_rd_en   - FIFO read enable, one-cycle pulse per byte
//   tx           - serial line, idle high
//   busy         - high whenever the FSM is not idle
//   frame_done   - one-cycle pulse on the last cycle of the last stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_W       = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rd_data,
   output logic              fifo_rd_en,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_W + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t              state, state_nx;
   logic [BAUD_W-1:0]   baud_cnt, baud_nx, baud_next;
   logic [BIT_W-1:0]    bit_cnt, bit_nx;
   logic [DATA_W-1:0]   shreg, shreg_nx;
   logic                par_bit, par_nx;
   logic                tx_nx, rd_en_nx, fd_nx;
   logic                baud_last;

   // Parity over the whole byte, inverted for odd parity.
   function automatic logic parity_of(input logic [DATA_W-1:0] d);
      return (^d) ^ (PARITY_ODD != 0);
   endfunction

   assign baud_last = (baud_cnt == BAUD_LAST);
   assign baud_next = baud_last ? '0 : baud_cnt + 1'b1;
   assign busy      = (state != S_IDLE);

   always_comb begin
      state_nx = state;
      baud_nx  = baud_cnt;
      bit_nx   = bit_cnt;
      shreg_nx = shreg;
      par_nx   = par_bit;

      case (state)
         S_IDLE: begin
            baud_nx = '0;
            bit_nx  = '0;
            if (enable && !fifo_empty) state_nx = S_FETCH;
         end
         S_FETCH: state_nx = S_LOAD;
         S_LOAD: begin
            // FIFO data is valid now, one cycle after the read pulse.
            shreg_nx = fifo_rd_data;
            par_nx   = parity_of(fifo_rd_data);
            baud_nx  = '0;
            bit_nx   = '0;
            state_nx = S_START;
         end
         S_START: begin
            baud_nx = baud_next;
            if (baud_last) state_nx = S_DATA;
         end
         S_DATA: begin
            baud_nx = baud_next;
            if (baud_last) begin
               shreg_nx = shreg >> 1;
               if (bit_cnt == DATA_LAST) begin
                  bit_nx   = '0;
                  state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_nx = bit_cnt + 1'b1;
               end
            end
         end
         S_PARITY: begin
            baud_nx = baud_next;
            if (baud_last) state_nx = S_STOP;
         end
         S_STOP: begin
            // The bit counter is reused to count stop bits.
            baud_nx = baud_next;
            if (baud_last) begin
               if (bit_cnt == STOP_LAST) begin
                  bit_nx   = '0;
                  state_nx = (enable && !fifo_empty) ? S_FETCH : S_IDLE;
               end else begin
                  bit_nx = bit_cnt + 1'b1;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // Outputs are derived from next-state values so they can be registered
      // and still line up exactly with the state they describe.
      tx_nx = 1'b1;
      case (state_nx)
         S_START:  tx_nx = 1'b0;
         S_DATA:   tx_nx = shreg_nx[0];
         S_PARITY: tx_nx = par_nx;
         default:  tx_nx = 1'b1;
      endcase
      rd_en_nx = (state_nx == S_FETCH);
      fd_nx    = (state_nx == S_STOP) && (baud_nx == BAUD_LAST) && (bit_nx == STOP_LAST);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         tx         <= 1'b1;
         fifo_rd_en <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         baud_cnt   <= baud_nx;
         bit_cnt    <= bit_nx;
         shreg      <= shreg_nx;
         par_bit    <= par_nx;
         tx         <= tx_nx;
         fifo_rd_en <= rd_en_nx;
         frame_done <= fd_nx;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4, DATA_W=8,
// STOP_BITS=1. Three instances: no parity (fed by a behavioural FIFO), even
// parity and odd parity (fed by a single-byte source). Frames on tx are
// decoded by sampling every cycle of every bit and compared with the frame
// built from the expected byte queue.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       enable = 1'b1;
   logic       empty_p1 = 1'b1;
   logic       empty_p2 = 1'b1;
   logic [7:0] par_data = 8'h00;

   logic [2:0] tx_w, busy_w, rd_w, fd_w;

   // Behavioural FIFO for the main instance.
   logic [7:0] mem [0:255];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   int         underflow = 0;
   logic [7:0] fifo_dout = 8'h00;
   logic       fifo_empty0;
   logic [7:0] exp_q [$];

   int cyc = 0;
   int rd_cnt [3] = '{0, 0, 0};
   int fd_cnt [3] = '{0, 0, 0};
   int last_rd [3] = '{-1, -1, -1};
   int last_fd [3] = '{-1, -1, -1};

   int n_cmp = 0;
   int n_err = 0;

   assign fifo_empty0 = (wr_ptr == rd_ptr);

   always #5 clk = ~clk;

   fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut (
      .clk(clk), .rstn(rstn), .enable(enable), .fifo_empty(fifo_empty0), .fifo_rd_data(fifo_dout),
      .fifo_rd_en(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));

   fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
      .clk(clk), .rstn(rstn), .enable(enable), .fifo_empty(empty_p1), .fifo_rd_data(par_data),
      .fifo_rd_en(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));

   fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
      .clk(clk), .rstn(rstn), .enable(enable), .fifo_empty(empty_p2), .fifo_rd_data(par_data),
      .fifo_rd_en(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));

   // Cycle counter: value at a negedge equals the number of posedges so far.
   always @(posedge clk) cyc <= cyc + 1;

   // FIFO read port: data registered, valid the cycle after r_en is sampled.
   always @(posedge clk) begin
      if (rd_w[0] === 1'b1) begin
         if (wr_ptr == rd_ptr) underflow <= underflow + 1;
         else begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
         end
      end
   end

   // Pulse monitors; record the negedge cycle index at which each pulse was seen.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rd_w[k] === 1'b1) begin
            rd_cnt[k]  <= rd_cnt[k] + 1;
            last_rd[k] <= cyc;
         end
         if (fd_w[k] === 1'b1) begin
            fd_cnt[k]  <= fd_cnt[k] + 1;
            last_fd[k] <= cyc;
         end
      end
   end

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 1;
      exp_q.push_back(b);
   endtask

   // Expected line levels for one frame, index 0 = start bit; unused slots high.
   function automatic logic [15:0] model_frame(input logic [7:0] b, input bit par, input bit odd);
      logic [15:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
      if (par) f[9] = ((($countones(b) % 2) == 1) ? 1'b1 : 1'b0) ^ odd;
      return f;
   endfunction

   // Waits (bounded) for a start bit on instance k, then samples every cycle of
   // nbits bits; ok drops if no start arrives or a bit is not held 4 cycles.
   // Returns on the negedge of the final stop-bit cycle.
   task automatic get_frame(input int k, input int nbits, input int drop_at,
                            output logic [15:0] bits, output int t0, output bit ok);
      int w;
      ok = 1'b1;
      bits = '1;
      t0 = -1;
      w = 0;
      while (tx_w[k] !== 1'b0 && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (tx_w[k] !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      t0 = cyc;
      for (int b = 0; b < nbits; b++) begin
         for (int s = 0; s < 4; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (b * 4 + s == drop_at) enable = 1'b0;
            if (s == 0) bits[b] = tx_w[k];
            else if (tx_w[k] !== bits[b]) ok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      int rd0, bad;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (tx_w !== 3'b111) begin n_err++; $display("FAIL reset_tx: got %b want 111", tx_w); end
      n_cmp++; if (busy_w !== 3'b000) begin n_err++; $display("FAIL reset_busy: got %b want 000", busy_w); end
      n_cmp++; if (rd_w !== 3'b000) begin n_err++; $display("FAIL reset_rd_en: got %b want 000", rd_w); end
      n_cmp++; if (fd_w !== 3'b000) begin n_err++; $display("FAIL reset_frame_done: got %b want 000", fd_w); end
      rstn = 1'b1;
      rd0 = rd_cnt[0];
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
      end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL empty_idle: %0d bad cycles, want 0", bad); end
      n_cmp++; if (rd_cnt[0] - rd0 != 0) begin n_err++; $display("FAIL empty_no_read: got %0d pulses want 0", rd_cnt[0] - rd0); end
   endtask

   task automatic test_single();
      logic [15:0] bits, expf;
      logic [7:0]  eb;
      int t0, rd0, fd0;
      bit ok;
      rd0 = rd_cnt[0];
      fd0 = fd_cnt[0];
      push(8'hA5);
      get_frame(0, 10, -1, bits, t0, ok);
      @(negedge clk);
      eb = exp_q.pop_front();
      expf = model_frame(eb, 1'b0, 1'b0);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL single_frame_seen: got %b want 1", ok); end
      n_cmp++; if (bits[9:0] !== 10'h34A) begin n_err++; $display("FAIL single_bits: got %h want 34a", bits[9:0]); end
      n_cmp++; if (bits !== expf) begin n_err++; $display("FAIL single_model: got %h want %h", bits, expf); end
      n_cmp++; if (rd_cnt[0] - rd0 != 1) begin n_err++; $display("FAIL single_rd_pulses: got %0d want 1", rd_cnt[0] - rd0); end
      n_cmp++; if (t0 - last_rd[0] != 2) begin n_err++; $display("FAIL single_latency: got %0d want 2", t0 - last_rd[0]); end
      n_cmp++; if (fd_cnt[0] - fd0 != 1) begin n_err++; $display("FAIL single_fd_pulses: got %0d want 1", fd_cnt[0] - fd0); end
      n_cmp++; if (last_fd[0] - t0 != 39) begin n_err++; $display("FAIL single_frame_len: got %0d want 39", last_fd[0] - t0); end
      n_cmp++; if (busy_w[0] !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", busy_w[0]); end
   endtask

   task automatic test_parity();
      logic [15:0] bits, expf;
      logic [7:0]  b;
      int t0, w;
      bit ok;
      for (int k = 1; k < 3; k++) begin
         for (int n = 0; n < 3; n++) begin
            b = (n == 0) ? 8'h07 : 8'($urandom_range(0, 255));
            par_data = b;
            if (k == 1) empty_p1 = 1'b0;
            else empty_p2 = 1'b0;
            w = 0;
            while (rd_w[k] !== 1'b1 && w < 50) begin
               @(negedge clk);
               w++;
            end
            empty_p1 = 1'b1;
            empty_p2 = 1'b1;
            n_cmp++; if (rd_w[k] !== 1'b1) begin n_err++; $display("FAIL parity_rd[%0d]: got %b want 1", k, rd_w[k]); end
            get_frame(k, 11, -1, bits, t0, ok);
            @(negedge clk);
            expf = model_frame(b, 1'b1, (k == 2));
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL parity_frame_seen[%0d]: got %b want 1", k, ok); end
            n_cmp++; if (bits !== expf) begin n_err++; $display("FAIL parity_model[%0d] byte %h: got %h want %h", k, b, bits, expf); end
            if (n == 0) begin
               n_cmp++;
               if (bits[9] !== ((k == 1) ? 1'b1 : 1'b0)) begin
                  n_err++; $display("FAIL parity_bit_07[%0d]: got %b want %b", k, bits[9], (k == 1));
               end
            end
            n_cmp++; if (last_fd[k] - t0 != 43) begin n_err++; $display("FAIL parity_frame_len[%0d]: got %0d want 43", k, last_fd[k] - t0); end
         end
      end
   endtask

   task automatic test_back_to_back(input bit rnd, input int n);
      logic [15:0] bits, expf;
      logic [7:0]  eb;
      int t0, prev, rd0, fd0, uf0;
      bit ok;
      rd0 = rd_cnt[0];
      fd0 = fd_cnt[0];
      uf0 = underflow;
      prev = -1;
      for (int i = 0; i < n; i++) push(rnd ? 8'($urandom) : 8'(8'h11 * (i + 1)));
      for (int i = 0; i < n; i++) begin
         get_frame(0, 10, -1, bits, t0, ok);
         eb = exp_q.pop_front();
         expf = model_frame(eb, 1'b0, 1'b0);
         n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_frame_seen[%0d]: got %b want 1", i, ok); end
         n_cmp++; if (bits !== expf) begin n_err++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, bits[8:1], eb); end
         if (i > 0) begin
            n_cmp++; if (t0 - prev != 42) begin n_err++; $display("FAIL b2b_period[%0d]: got %0d want 42", i, t0 - prev); end
         end
         prev = t0;
      end
      @(negedge clk);
      n_cmp++; if (rd_cnt[0] - rd0 != n) begin n_err++; $display("FAIL b2b_rd_pulses: got %0d want %0d", rd_cnt[0] - rd0, n); end
      n_cmp++; if (fd_cnt[0] - fd0 != n) begin n_err++; $display("FAIL b2b_fd_pulses: got %0d want %0d", fd_cnt[0] - fd0, n); end
      n_cmp++; if (underflow != uf0) begin n_err++; $display("FAIL b2b_underflow: got %0d want %0d", underflow, uf0); end
      n_cmp++; if (wr_ptr - rd_ptr != 0) begin n_err++; $display("FAIL b2b_level: got %0d want 0", wr_ptr - rd_ptr); end
   endtask

   task automatic test_enable_drop();
      logic [15:0] bits, expf;
      logic [7:0]  eb;
      int t0, rd0;
      bit ok;
      rd0 = rd_cnt[0];
      for (int i = 0; i < 3; i++) push(8'($urandom));
      for (int i = 0; i < 2; i++) begin
         get_frame(0, 10, (i == 1) ? 14 : -1, bits, t0, ok);
         eb = exp_q.pop_front();
         expf = model_frame(eb, 1'b0, 1'b0);
         n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL drop_frame_seen[%0d]: got %b want 1", i, ok); end
         n_cmp++; if (bits !== expf) begin n_err++; $display("FAIL drop_byte[%0d]: got %h want %h", i, bits, expf); end
      end
      n_cmp++; if (busy_w[0] !== 1'b1 || fd_w[0] !== 1'b1) begin n_err++; $display("FAIL drop_busy_at_done: got busy %b fd %b want 1 1", busy_w[0], fd_w[0]); end
      @(negedge clk);
      n_cmp++; if (busy_w[0] !== 1'b0) begin n_err++; $display("FAIL drop_busy_after: got %b want 0", busy_w[0]); end
      repeat (60) @(negedge clk);
      n_cmp++; if (rd_cnt[0] - rd0 != 2) begin n_err++; $display("FAIL drop_rd_pulses: got %0d want 2", rd_cnt[0] - rd0); end
      n_cmp++; if (wr_ptr - rd_ptr != 1) begin n_err++; $display("FAIL drop_level: got %0d want 1", wr_ptr - rd_ptr); end
      n_cmp++; if (tx_w[0] !== 1'b1) begin n_err++; $display("FAIL drop_tx_idle: got %b want 1", tx_w[0]); end
      enable = 1'b1;
      get_frame(0, 10, -1, bits, t0, ok);
      @(negedge clk);
      eb = exp_q.pop_front();
      expf = model_frame(eb, 1'b0, 1'b0);
      n_cmp++; if (ok !== 1'b1 || bits !== expf) begin n_err++; $display("FAIL drop_third: got %h ok %b want %h", bits, ok, expf); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] bits, expf;
      logic [7:0]  eb;
      int t0, rd0, w;
      bit ok;
      rd0 = rd_cnt[0];
      push(8'h00);
      w = 0;
      while (tx_w[0] !== 1'b0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      repeat (6) @(negedge clk);
      n_cmp++; if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin n_err++; $display("FAIL mid_in_data: got tx %b busy %b want 0 1", tx_w[0], busy_w[0]); end
      #1 rstn = 1'b0;
      #1;
      n_cmp++; if (tx_w[0] !== 1'b1) begin n_err++; $display("FAIL mid_rst_tx: got %b want 1", tx_w[0]); end
      n_cmp++; if (busy_w[0] !== 1'b0 || rd_w[0] !== 1'b0 || fd_w[0] !== 1'b0) begin
         n_err++; $display("FAIL mid_rst_outputs: got busy %b rd %b fd %b want 0 0 0", busy_w[0], rd_w[0], fd_w[0]);
      end
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      void'(exp_q.pop_front());
      repeat (10) @(negedge clk);
      n_cmp++; if (rd_cnt[0] - rd0 != 1 || wr_ptr - rd_ptr != 0) begin
         n_err++; $display("FAIL mid_no_reread: got %0d pulses level %0d want 1 0", rd_cnt[0] - rd0, wr_ptr - rd_ptr);
      end
      push(8'h3C);
      get_frame(0, 10, -1, bits, t0, ok);
      @(negedge clk);
      eb = exp_q.pop_front();
      expf = model_frame(eb, 1'b0, 1'b0);
      n_cmp++; if (ok !== 1'b1 || bits !== expf) begin n_err++; $display("FAIL mid_after_3c: got %h ok %b want %h", bits, ok, expf); end
      n_cmp++; if (rd_cnt[0] - rd0 != 2) begin n_err++; $display("FAIL mid_rd_pulses: got %0d want 2", rd_cnt[0] - rd0); end
   endtask

   initial begin
      #1;
      test_reset();
      test_single();
      test_parity();
      test_back_to_back(1'b0, 3);
      test_back_to_back(1'b1, 8);
      test_enable_drop();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream consumer for the synchronous FIFO: pops bytes from the FIFO read port and serialises each one as an asynchronous UART frame (start bit, LSB-first data, optional parity, stop bits) on a single `tx` line. It sits between the FIFO's read side and the chip pad. It owns the FIFO read-enable and never reads an empty FIFO.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit. Must be ≥ 2.
- `DATA_W`, 8: data bits per frame. Must match the FIFO width.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock, rising-edge.
- `rstn`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: permits starting new frames.
- `fifo_empty`, in, 1: FIFO `empty` flag.
- `fifo_rd_data`, in, DATA_W: FIFO `data_out`.
- `fifo_rd_en`, out, 1: FIFO `r_en`. One-cycle pulse per byte.
- `tx`, out, 1: serial line, idle high.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `frame_done`, out, 1: one-cycle pulse on the final cycle of the last stop bit.

## Operation
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: when `enable`=1 and `fifo_empty`=0, go to FETCH.
- FETCH: `fifo_rd_en`=1 for exactly this one cycle, then go to LOAD.
- LOAD: capture `fifo_rd_data` into the shift register, then go to START. FIFO read data is registered and is valid the cycle after `r_en` is sampled high.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx` = shift register bit 0. Shift right every CLKS_PER_BIT cycles. After DATA_W bits, go to PARITY if `PARITY_EN`=1, otherwise go to STOP.
- PARITY: `tx` = XOR of the data bits (even parity) or its inverse (odd parity), held for CLKS_PER_BIT cycles.
- STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles. `frame_done` pulses on the final cycle. Next state is FETCH if `enable`=1 and `fifo_empty`=0 at that cycle, otherwise IDLE.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Bit counter is $clog2(DATA_W+1) bits wide.
- `enable` deasserted mid-frame: the current frame completes unchanged, then the FSM goes to IDLE. No further reads occur.
- `fifo_empty` is sampled only in IDLE and on the last STOP cycle. `fifo_rd_en` is never asserted while `fifo_empty`=1.
- `tx`, `fifo_rd_en` and `frame_done` are registered/state-decoded outputs. They are glitch-free.
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0, state=IDLE, all counters 0, shift register 0.
- Reset mid-operation: outputs return to reset values asynchronously. A byte already popped is discarded and is not re-read.

## Timing
- Start latency: FIFO non-empty sampled in IDLE at edge N gives `fifo_rd_en` high during N..N+1, data captured at N+2, and `tx` falling after edge N+2.
- Frame length: (1 + DATA_W + PARITY_EN + STOP_BITS)×CLKS_PER_BIT cycles of `tx` activity.
- Back-to-back frames: start-to-start period is frame length + 2 cycles. The FETCH and LOAD cycles hold `tx`=1 and are added to the stop time.
- Throughput: at most one FIFO pop per frame period.
- `busy` rises the cycle after IDLE exits and falls the cycle IDLE is re-entered.

## Test plan
Unless stated otherwise: CLKS_PER_BIT=4, DATA_W=8, STOP_BITS=1.
- Reset, then FIFO empty for 100 cycles → `tx`=1, `busy`=0, zero `fifo_rd_en` pulses.
- Push 0xA5, `PARITY_EN`=0 → one `fifo_rd_en` pulse. `tx` = 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles. `tx` falls 2 cycles after the `fifo_rd_en` pulse. `frame_done` pulses once at the end of the 40-cycle frame.
- Parity: 0x07 with even parity → parity bit 1. 0x07 with odd parity → parity bit 0. Frame is 44 cycles.
- Push 0x11, 0x22, 0x33 back-to-back → exactly 3 `fifo_rd_en` pulses, start bits 42 cycles apart, decoded bytes equal the pushed queue in order. The FIFO never underflows.
- `enable` dropped during the second of 3 frames → the second frame completes intact, the third byte stays in the FIFO, and `busy` falls after `frame_done`.
- `rstn` asserted mid-DATA → `tx`=1 immediately, with no clock edge needed. After release, the next pushed byte 0x3C is transmitted correctly.
